// File: rtl/video_timing_gen.sv
// Raster timing source: pixel-clock enable, H/V sync and blanking, and pixel
// coordinates, with a run-time choice between two active line counts.
module video_timing_gen #(
  parameter int   H_ACTIVE     = 256,
  parameter int   H_FP         = 24,
  parameter int   H_SYNC       = 32,
  parameter int   H_BP         = 29,
  parameter int   V_ACTIVE     = 240,
  parameter int   V_ACTIVE_ALT = 224,
  parameter int   V_FP         = 4,
  parameter int   V_SYNC       = 3,
  parameter int   V_BP         = 15,
  parameter logic SYNC_POL     = 1'b0,
  parameter int   CNT_WIDTH    = 10
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [2:0]           ce_divider,
  input  logic                 lines_alt,
  output logic                 ce_pix,
  output logic [CNT_WIDTH-1:0] hcount,
  output logic [CNT_WIDTH-1:0] vcount,
  output logic                 HSync,
  output logic                 VSync,
  output logic                 HBlank,
  output logic                 VBlank,
  output logic                 de,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
  localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VA_C     = cnt_t'(V_ACTIVE);
  localparam cnt_t VA_ALT_C = cnt_t'(V_ACTIVE_ALT);
  localparam cnt_t V_FP_C   = cnt_t'(V_FP);
  localparam cnt_t V_SYNC_C = cnt_t'(V_SYNC);

  if (V_ACTIVE_ALT > V_ACTIVE) begin : g_chk_alt
    $error("V_ACTIVE_ALT must not exceed V_ACTIVE");
  end
  if (H_TOTAL > (2 ** CNT_WIDTH) || V_TOTAL > (2 ** CNT_WIDTH)) begin : g_chk_width
    $error("Raster totals do not fit in CNT_WIDTH bits");
  end

  logic [3:0] div_q, div_d, div_end;
  logic [2:0] lim_q, lim_d, lim_eff;
  logic       first_q, first_d;
  logic       div_wrap;
  logic       ce_q, ce_d;

  cnt_t       hcount_q, hcount_d, vcount_q, vcount_d;
  logic       alt_q, alt_d;
  logic       h_wrap, v_wrap;
  cnt_t       va, vfp, vs_start, vs_end;

  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       hblank_q, hblank_d, vblank_q, vblank_d;
  logic       de_q, de_d, fs_q, fs_d;

  // Divider: the limit is latched at each wrap so a mid-period change of
  // ce_divider never shortens the period in progress. Until the first wrap
  // after reset there is no latched value, so the live input is used.
  always_comb begin
    lim_eff  = first_q ? ce_divider : lim_q;
    div_end  = {1'b0, lim_eff} + 4'd1;
    div_wrap = (div_q >= div_end);
    div_d    = div_wrap ? 4'd0 : div_q + 4'd1;
    lim_d    = div_wrap ? ce_divider : lim_q;
    first_d  = first_q & ~div_wrap;
    ce_d     = ~div_wrap & (div_d == div_end);
  end

  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    alt_d    = alt_q;
    fs_d     = 1'b0;
    if (ce_q) begin
      hcount_d = h_wrap ? '0 : hcount_q + cnt_t'(1);
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + cnt_t'(1);
        if (v_wrap) begin
          alt_d = lines_alt;
          fs_d  = 1'b1;
        end
      end
    end
  end

  // Decode the next position so sync/blank land on the same edge as the counters.
  always_comb begin
    va       = alt_d ? VA_ALT_C : VA_C;
    vfp      = V_FP_C + (VA_C - va);
    vs_start = va + vfp;
    vs_end   = vs_start + V_SYNC_C;
    hblank_d = (hcount_d >= H_ACT_C);
    vblank_d = (vcount_d >= va);
    hsync_d  = (hcount_d >= HS_START && hcount_d < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = (vcount_d >= vs_start && vcount_d < vs_end) ? SYNC_POL : ~SYNC_POL;
    de_d     = ~hblank_d & ~vblank_d;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      lim_q    <= '0;
      first_q  <= 1'b1;
      ce_q     <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      alt_q    <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      lim_q    <= lim_d;
      first_q  <= first_d;
      ce_q     <= ce_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      alt_q    <= alt_d;
      fs_q     <= fs_d;
      // Decoded outputs only move with the counters, holding between pulses.
      if (ce_q) begin
        hsync_q  <= hsync_d;
        vsync_q  <= vsync_d;
        hblank_q <= hblank_d;
        vblank_q <= vblank_d;
        de_q     <= de_d;
      end
    end
  end

  assign ce_pix      = ce_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign HBlank      = hblank_q;
  assign VBlank      = vblank_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule
